// File: rtl/result_reader_if.sv
// Bundles the readout control, ResultSRAM read port and pixel stream of result_reader.
// master is the reader's view; slave is the view of whatever surrounds it.
interface result_reader_if #(
    parameter int ADDR_W = 14,
    parameter int PIX_W  = 8
);
    logic              START;
    logic [5:0]        TW;
    logic [5:0]        TH;

    logic [ADDR_W-1:0] SRAM_A;
    logic              SRAM_CEN;
    logic              SRAM_WEN;
    logic [PIX_W-1:0]  SRAM_Q;

    logic [PIX_W-1:0]  PIX_DATA;
    logic              PIX_VALID;
    logic              PIX_READY;
    logic [5:0]        PIX_X;
    logic [5:0]        PIX_Y;
    logic              PIX_LAST;

    logic              BUSY;
    logic              FIN;
    logic [15:0]       CHKSUM;

    modport master (
        input  START, TW, TH, SRAM_Q, PIX_READY,
        output SRAM_A, SRAM_CEN, SRAM_WEN,
        output PIX_DATA, PIX_VALID, PIX_X, PIX_Y, PIX_LAST,
        output BUSY, FIN, CHKSUM
    );

    modport slave (
        output START, TW, TH, SRAM_Q, PIX_READY,
        input  SRAM_A, SRAM_CEN, SRAM_WEN,
        input  PIX_DATA, PIX_VALID, PIX_X, PIX_Y, PIX_LAST,
        input  BUSY, FIN, CHKSUM
    );
endinterface

// File: rtl/result_reader.sv
// Streams a TW x TH frame out of ResultSRAM, one pixel per FETCH/CAPT/SEND pass.
// Optional frame checksum enabled by defining RESULT_READER_CHKSUM_EN.
module result_reader #(
    parameter int ADDR_W = 14,
    parameter int PIX_W  = 8
) (
    input  logic           CLK,
    input  logic           RST,
    result_reader_if.master bus
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        CAPT,
        SEND,
        FIN
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_ONE = 1;

    state_t            state;
    logic [5:0]        tw_q;
    logic [5:0]        th_q;
    logic [5:0]        x_cnt;
    logic [5:0]        y_cnt;
    logic [ADDR_W-1:0] addr;
    logic [PIX_W-1:0]  pix_data;
    logic              pix_valid;
    logic              pix_last;
    logic              busy;
    logic              fin;
    logic              cen;
`ifdef RESULT_READER_CHKSUM_EN
    logic [15:0]       chksum;
`endif

    logic x_at_end;
    logic y_at_end;

    assign x_at_end = (x_cnt == tw_q - 6'd1);
    assign y_at_end = (y_cnt == th_q - 6'd1);

    // The address is stepped alongside X/Y so it always equals Y*TW+X without a multiplier.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            tw_q      <= '0;
            th_q      <= '0;
            x_cnt     <= '0;
            y_cnt     <= '0;
            addr      <= '0;
            pix_data  <= '0;
            pix_valid <= 1'b0;
            pix_last  <= 1'b0;
            busy      <= 1'b0;
            fin       <= 1'b0;
            cen       <= 1'b1;
`ifdef RESULT_READER_CHKSUM_EN
            chksum    <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.START) begin
                        tw_q  <= bus.TW;
                        th_q  <= bus.TH;
                        x_cnt <= '0;
                        y_cnt <= '0;
                        addr  <= '0;
                        busy  <= 1'b1;
`ifdef RESULT_READER_CHKSUM_EN
                        chksum <= '0;
`endif
                        if ((bus.TW == 6'd0) || (bus.TH == 6'd0)) begin
                            state <= FIN;
                            fin   <= 1'b1;
                        end else begin
                            state <= FETCH;
                            cen   <= 1'b0;
                        end
                    end
                end

                FETCH: begin
                    cen   <= 1'b1;
                    state <= CAPT;
                end

                CAPT: begin
                    pix_data  <= bus.SRAM_Q;
                    pix_valid <= 1'b1;
                    pix_last  <= x_at_end && y_at_end;
                    state     <= SEND;
                end

                SEND: begin
                    if (bus.PIX_READY) begin
                        pix_valid <= 1'b0;
                        pix_last  <= 1'b0;
`ifdef RESULT_READER_CHKSUM_EN
                        chksum    <= chksum + 16'(pix_data);
`endif
                        if (pix_last) begin
                            state <= FIN;
                            fin   <= 1'b1;
                        end else begin
                            if (x_at_end) begin
                                x_cnt <= '0;
                                y_cnt <= y_cnt + 6'd1;
                            end else begin
                                x_cnt <= x_cnt + 6'd1;
                            end
                            addr  <= addr + ADDR_ONE;
                            cen   <= 1'b0;
                            state <= FETCH;
                        end
                    end
                end

                FIN: begin
                    fin   <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                    cen   <= 1'b1;
                    fin   <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.SRAM_A    = addr;
    assign bus.SRAM_CEN  = cen;
    assign bus.SRAM_WEN  = 1'b1;
    assign bus.PIX_DATA  = pix_data;
    assign bus.PIX_VALID = pix_valid;
    assign bus.PIX_X     = x_cnt;
    assign bus.PIX_Y     = y_cnt;
    assign bus.PIX_LAST  = pix_last;
    assign bus.BUSY      = busy;
    assign bus.FIN       = fin;
`ifdef RESULT_READER_CHKSUM_EN
    assign bus.CHKSUM    = chksum;
`else
    assign bus.CHKSUM    = 16'd0;
`endif

endmodule

// File: tb/tb_result_reader.sv
// Directed self-checking bench for result_reader: framing, stalls, ignored START,
// mid-frame reset and the largest 63x63 frame.
module tb_result_reader;

    localparam int ADDR_W = 14;
    localparam int PIX_W  = 8;

    typedef struct packed {
        logic [7:0] d;
        logic [5:0] x;
        logic [5:0] y;
        logic       last;
    } pix_t;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    result_reader_if #(.ADDR_W(ADDR_W), .PIX_W(PIX_W)) bus ();

    result_reader #(.ADDR_W(ADDR_W), .PIX_W(PIX_W)) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    logic [PIX_W-1:0] mem [0:4095];
    logic [PIX_W-1:0] sramQ = '0;
    assign bus.SRAM_Q = sramQ;

    always @(posedge CLK) begin
        if (!bus.SRAM_CEN) sramQ <= mem[bus.SRAM_A[11:0]];
    end

    pix_t pixQ[$];
    int   fetchCount [0:4095];
    int   fetchTotal;
    int   firstFetchAddr;
    int   validCycles;
    int   finCycles;
    int   checkCount = 0;
    int   passCount  = 0;

    // Everything DUT-driven is stable at the falling edge; a handshake seen here completes on the next rise.
    always @(negedge CLK) begin
        if (bus.PIX_VALID && bus.PIX_READY)
            pixQ.push_back(pix_t'{bus.PIX_DATA, bus.PIX_X, bus.PIX_Y, bus.PIX_LAST});
        if (!bus.SRAM_CEN) begin
            if (fetchTotal == 0) firstFetchAddr = int'(bus.SRAM_A);
            fetchCount[bus.SRAM_A[11:0]]++;
            fetchTotal++;
        end
        if (bus.PIX_VALID) validCycles++;
        if (bus.FIN) finCycles++;
    end

    function automatic int expChk(input int sum);
`ifdef RESULT_READER_CHKSUM_EN
        return sum % 65536;
`else
        return 0;
`endif
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed === expected) passCount++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    endtask

    task automatic clearStats();
        pixQ.delete();
        foreach (fetchCount[i]) fetchCount[i] = 0;
        fetchTotal     = 0;
        firstFetchAddr = -1;
        validCycles    = 0;
        finCycles      = 0;
    endtask

    // Leaves the caller just after the edge that accepted START, i.e. in cycle 1.
    task automatic applyStimulus(input logic [5:0] tw, input logic [5:0] th);
        @(posedge CLK); #1;
        bus.START = 1'b1;
        bus.TW    = tw;
        bus.TH    = th;
        @(posedge CLK); #1;
        bus.START = 1'b0;
    endtask

    task automatic waitFin(input int budget, output int cycles);
        bit found = 1'b0;
        cycles = 0;
        for (int i = 1; i <= budget; i++) begin
            @(negedge CLK);
            if (bus.FIN) begin
                cycles = i;
                found  = 1'b1;
                break;
            end
        end
        if (!found) checkOutput("fin_timeout", 0, 1);
    endtask

    task automatic waitValid(input int budget);
        bit found = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge CLK);
            if (bus.PIX_VALID) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) checkOutput("valid_timeout", 0, 1);
    endtask

    task automatic checkResetOutputs(input string pfx);
        checkOutput({pfx, "_valid"},  bus.PIX_VALID, 0);
        checkOutput({pfx, "_data"},   bus.PIX_DATA,  0);
        checkOutput({pfx, "_x"},      bus.PIX_X,     0);
        checkOutput({pfx, "_y"},      bus.PIX_Y,     0);
        checkOutput({pfx, "_last"},   bus.PIX_LAST,  0);
        checkOutput({pfx, "_busy"},   bus.BUSY,      0);
        checkOutput({pfx, "_fin"},    bus.FIN,       0);
        checkOutput({pfx, "_chksum"}, bus.CHKSUM,    0);
        checkOutput({pfx, "_sram_a"}, bus.SRAM_A,    0);
        checkOutput({pfx, "_cen"},    bus.SRAM_CEN,  1);
        checkOutput({pfx, "_wen"},    bus.SRAM_WEN,  1);
    endtask

    initial begin
        int c;
        int lastFlags;
        int waited;
        logic [7:0] exp2x2 [4];
        exp2x2 = '{8'd10, 8'd20, 8'd30, 8'd40};

        foreach (mem[i]) mem[i] = '0;
        RST           = 1'b1;
        bus.START     = 1'b0;
        bus.TW        = 6'd0;
        bus.TH        = 6'd0;
        bus.PIX_READY = 1'b0;
        clearStats();

        repeat (3) @(posedge CLK);
        #1 RST = 1'b0;
        @(negedge CLK);
        checkResetOutputs("reset");

        $display("[TB] 2x2 frame");
        mem[0] = 8'd10; mem[1] = 8'd20; mem[2] = 8'd30; mem[3] = 8'd40;
        bus.PIX_READY = 1'b1;
        clearStats();
        applyStimulus(6'd2, 6'd2);
        waitFin(40, c);
        checkOutput("f2_fin_cycle", c, 13);
        checkOutput("f2_busy_at_fin", bus.BUSY, 1);
        checkOutput("f2_npix", pixQ.size(), 4);
        if (pixQ.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                checkOutput($sformatf("f2_d%0d", i), pixQ[i].d, exp2x2[i]);
                checkOutput($sformatf("f2_x%0d", i), pixQ[i].x, i % 2);
                checkOutput($sformatf("f2_y%0d", i), pixQ[i].y, i / 2);
                checkOutput($sformatf("f2_last%0d", i), pixQ[i].last, (i == 3) ? 1 : 0);
            end
        end
        checkOutput("f2_chksum", bus.CHKSUM, expChk(100));
        @(negedge CLK);
        checkOutput("f2_fin_pulse", bus.FIN, 0);
        checkOutput("f2_busy_after", bus.BUSY, 0);
        repeat (3) @(negedge CLK);
        checkOutput("f2_chksum_hold", bus.CHKSUM, expChk(100));

        $display("[TB] 3x1 frame with stall");
        mem[0] = 8'd5; mem[1] = 8'd6; mem[2] = 8'd7;
        bus.PIX_READY = 1'b0;
        clearStats();
        applyStimulus(6'd3, 6'd1);
        waitValid(20);
        @(posedge CLK); #1 bus.PIX_READY = 1'b1;
        @(posedge CLK); #1 bus.PIX_READY = 1'b0;
        waitValid(20);
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("st_valid%0d", i), bus.PIX_VALID, 1);
            checkOutput($sformatf("st_data%0d", i), bus.PIX_DATA, 6);
            checkOutput($sformatf("st_x%0d", i), bus.PIX_X, 1);
            checkOutput($sformatf("st_cen%0d", i), bus.SRAM_CEN, 1);
            if (i < 4) @(negedge CLK);
        end
        @(posedge CLK); #1 bus.PIX_READY = 1'b1;
        waitFin(40, c);
        checkOutput("st_npix", pixQ.size(), 3);
        if (pixQ.size() == 3) begin
            for (int i = 0; i < 3; i++) begin
                checkOutput($sformatf("st_d%0d", i), pixQ[i].d, 5 + i);
                checkOutput($sformatf("st_x%0d", i), pixQ[i].x, i);
            end
        end
        for (int i = 0; i < 3; i++)
            checkOutput($sformatf("st_fetch%0d", i), fetchCount[i], 1);
        checkOutput("st_fetch_total", fetchTotal, 3);
        checkOutput("st_chksum", bus.CHKSUM, expChk(18));

        $display("[TB] empty frame");
        @(negedge CLK);
        clearStats();
        applyStimulus(6'd0, 6'd5);
        waitFin(10, c);
        checkOutput("z_fin_cycle", c, 1);
        checkOutput("z_busy", bus.BUSY, 1);
        checkOutput("z_fetches", fetchTotal, 0);
        checkOutput("z_valid", validCycles, 0);
        @(negedge CLK);
        checkOutput("z_fin_pulse", bus.FIN, 0);
        checkOutput("z_busy_after", bus.BUSY, 0);

        $display("[TB] START ignored mid-frame");
        mem[0] = 8'd11; mem[1] = 8'd22;
        clearStats();
        applyStimulus(6'd2, 6'd1);
        @(posedge CLK); #1;
        bus.START = 1'b1; bus.TW = 6'd7; bus.TH = 6'd7;
        @(posedge CLK); #1;
        bus.START = 1'b0;
        waitFin(40, c);
        checkOutput("ig_fin_cycle", c, 5);
        checkOutput("ig_npix", pixQ.size(), 2);
        if (pixQ.size() == 2) begin
            checkOutput("ig_d1", pixQ[1].d, 22);
            checkOutput("ig_x1", pixQ[1].x, 1);
            checkOutput("ig_last1", pixQ[1].last, 1);
        end
        checkOutput("ig_fetches", fetchTotal, 2);

        $display("[TB] reset mid-frame");
        for (int i = 0; i < 16; i++) mem[i] = 8'(50 + i);
        @(negedge CLK);
        clearStats();
        applyStimulus(6'd4, 6'd4);
        waited = 0;
        while (pixQ.size() < 3 && waited < 40) begin
            @(negedge CLK);
            waited++;
        end
        checkOutput("rs_reached_3", pixQ.size(), 3);
        @(posedge CLK); #1 RST = 1'b1;
        @(posedge CLK); #1 RST = 1'b0;
        @(negedge CLK);
        checkResetOutputs("rs");
        finCycles = 0;
        repeat (10) @(negedge CLK);
        checkOutput("rs_no_fin", finCycles, 0);
        clearStats();
        applyStimulus(6'd2, 6'd1);
        waitFin(40, c);
        checkOutput("rs_first_addr", firstFetchAddr, 0);
        checkOutput("rs_npix", pixQ.size(), 2);
        if (pixQ.size() == 2) checkOutput("rs_d0", pixQ[0].d, 50);
        checkOutput("rs_chksum", bus.CHKSUM, expChk(101));

        $display("[TB] 63x63 frame");
        for (int i = 0; i < 3969; i++) mem[i] = 8'd255;
        @(negedge CLK);
        clearStats();
        applyStimulus(6'd63, 6'd63);
        waitFin(12000, c);
        checkOutput("big_fin_cycle", c, 11908);
        checkOutput("big_sram_a", bus.SRAM_A, 3968);
        checkOutput("big_chksum", bus.CHKSUM, expChk(3969 * 255));
        checkOutput("big_npix", pixQ.size(), 3969);
        checkOutput("big_fetches", fetchTotal, 3969);
        lastFlags = 0;
        foreach (pixQ[i]) if (pixQ[i].last) lastFlags++;
        checkOutput("big_last_count", lastFlags, 1);
        if (pixQ.size() == 3969) begin
            checkOutput("big_last_x", pixQ[3968].x, 62);
            checkOutput("big_last_y", pixQ[3968].y, 62);
            checkOutput("big_last_flag", pixQ[3968].last, 1);
            checkOutput("big_d_mid", pixQ[2000].d, 255);
        end

        repeat (2) @(negedge CLK);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
